// File: rtl/mips_multicycle_controller_pkg.sv
// mips_multicycle_controller_pkg: opcodes, funct codes, ALU control codes and FSM types
// shared by the multicycle MIPS controller.
package mips_multicycle_controller_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [2:0] AC_ADD  = 3'b010;
  localparam logic [2:0] AC_SUB  = 3'b110;
  localparam logic [2:0] AC_AND  = 3'b000;
  localparam logic [2:0] AC_OR   = 3'b001;
  localparam logic [2:0] AC_SLT  = 3'b111;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_RTYPEWB, S_BEQEX, S_BNEEX, S_ADDIEX, S_LOGIEX, S_IMMWB, S_JEX
  } state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_AND, ALU_OR} aluop_t;
endpackage

// File: rtl/mips_multicycle_controller_aludec.sv
// mips_multicycle_controller_aludec: maps the FSM's ALU operation class and the
// instruction funct field to the ALU control code.
module mips_multicycle_controller_aludec
  import mips_multicycle_controller_pkg::*;
(
  input  aluop_t     i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);
  logic [2:0] w_fn;
  always_comb begin
    // unknown funct falls back to add rather than propagating X
    w_fn = i_funct == FN_SUB ? AC_SUB :
           i_funct == FN_AND ? AC_AND :
           i_funct == FN_OR  ? AC_OR  :
           i_funct == FN_SLT ? AC_SLT : AC_ADD;
    o_alucontrol = i_aluop == ALU_SUB   ? AC_SUB :
                   i_aluop == ALU_FUNCT ? w_fn   :
                   i_aluop == ALU_AND   ? AC_AND :
                   i_aluop == ALU_OR    ? AC_OR  : AC_ADD;
  end
endmodule

// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared-memory multicycle MIPS datapath.
module mips_multicycle_controller
  import mips_multicycle_controller_pkg::*;
#(
  parameter bit EN_BNE       = 1'b1,
  parameter bit EN_LOGIC_IMM = 1'b1,
  parameter bit EN_MEMREADY  = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_memready,
  output logic       o_iord,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_regwrite,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic       o_immzext,
  output logic [1:0] o_pcsrc,
  output logic       o_pcen,
  output logic [2:0] o_alucontrol,
  output logic       o_illegal
);
  state_t r_state, w_next;
  aluop_t w_aluop;
  logic w_mr, w_pcwrite, w_branch, w_branchn;
  assign w_mr = EN_MEMREADY ? i_memready : 1'b1;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_FETCH;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_aluop = ALU_ADD;
    w_pcwrite = 1'b0;
    w_branch = 1'b0;
    w_branchn = 1'b0;
    o_iord = 1'b0;
    o_memwrite = 1'b0;
    o_irwrite = 1'b0;
    o_regdst = 1'b0;
    o_memtoreg = 1'b0;
    o_regwrite = 1'b0;
    o_alusrca = 1'b0;
    o_alusrcb = 2'b00;
    o_immzext = 1'b0;
    o_pcsrc = 2'b00;
    o_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_alusrcb = 2'b01;
        o_irwrite = w_mr;
        w_pcwrite = w_mr;
        w_next = w_mr ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        o_alusrcb = 2'b11;
        case (i_op)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_R:             w_next = S_RTYPEEX;
          OP_BEQ:           w_next = S_BEQEX;
          OP_BNE:           w_next = EN_BNE ? S_BNEEX : S_FETCH;
          OP_ADDI:          w_next = S_ADDIEX;
          OP_ANDI, OP_ORI:  w_next = EN_LOGIC_IMM ? S_LOGIEX : S_FETCH;
          OP_J:             w_next = S_JEX;
          default:          w_next = S_FETCH;
        endcase
        // every legal opcode leaves DECODE for an execute state
        o_illegal = w_next == S_FETCH;
      end
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        w_next = i_op == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        o_iord = 1'b1;
        w_next = w_mr ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        o_memtoreg = 1'b1;
        o_regwrite = 1'b1;
        w_next = S_FETCH;
      end
      S_MEMWR: begin
        o_iord = 1'b1;
        o_memwrite = 1'b1;
        w_next = w_mr ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        o_alusrca = 1'b1;
        w_aluop = ALU_FUNCT;
        w_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        o_regdst = 1'b1;
        o_regwrite = 1'b1;
        w_next = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        o_alusrca = 1'b1;
        w_aluop = ALU_SUB;
        o_pcsrc = 2'b01;
        w_branch = r_state == S_BEQEX;
        w_branchn = r_state == S_BNEEX;
        w_next = S_FETCH;
      end
      S_ADDIEX, S_LOGIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = 2'b10;
        o_immzext = r_state == S_LOGIEX;
        w_aluop = r_state == S_ADDIEX ? ALU_ADD : i_op == OP_ANDI ? ALU_AND : ALU_OR;
        w_next = S_IMMWB;
      end
      S_IMMWB: begin
        o_regwrite = 1'b1;
        w_next = S_FETCH;
      end
      S_JEX: begin
        o_pcsrc = 2'b10;
        w_pcwrite = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end
  assign o_pcen = w_pcwrite | (w_branch & i_zero) | (w_branchn & ~i_zero);
  mips_multicycle_controller_aludec u_aludec (
    .i_aluop     (w_aluop),
    .i_funct     (i_funct),
    .o_alucontrol(o_alucontrol)
  );
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller: two controller configurations driven by directed and
// random instruction streams, checked every cycle against an instruction-level model.
module tb_mips_multicycle_controller;
  typedef struct packed {
    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic immzext;
    logic [1:0] pcsrc;
    logic pcen;
    logic [2:0] alucontrol;
    logic illegal;
  } ov_t;
  typedef enum {FE, DE, ADR, RD, MWB, WR, REX, RWB, BQ, BN, IEX, LEX, IWB, JMP} step_t;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04,
    OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_J = 6'h02;
  localparam ov_t CARE = 17'h1FFFF, CARE_NOAC = 17'h1FFF1;
  localparam ov_t L_F1   = 17'b0_0_1_0_0_0_0_01_0_00_1_010_0;
  localparam ov_t L_F0   = 17'b0_0_0_0_0_0_0_01_0_00_0_010_0;
  localparam ov_t L_D    = 17'b0_0_0_0_0_0_0_11_0_00_0_010_0;
  localparam ov_t L_DILL = 17'b0_0_0_0_0_0_0_11_0_00_0_010_1;
  localparam ov_t L_ADR  = 17'b0_0_0_0_0_0_1_10_0_00_0_010_0;
  localparam ov_t L_RD   = 17'b1_0_0_0_0_0_0_00_0_00_0_000_0;
  localparam ov_t L_MWB  = 17'b0_0_0_0_1_1_0_00_0_00_0_000_0;
  localparam ov_t L_WR   = 17'b1_1_0_0_0_0_0_00_0_00_0_000_0;
  localparam ov_t L_BR1  = 17'b0_0_0_0_0_0_1_00_0_01_1_110_0;
  localparam ov_t L_BR0  = 17'b0_0_0_0_0_0_1_00_0_01_0_110_0;
  localparam ov_t L_ORI  = 17'b0_0_0_0_0_0_1_10_1_00_0_001_0;
  localparam ov_t L_IWB  = 17'b0_0_0_0_0_1_0_00_0_00_0_000_0;
  localparam ov_t L_SLT  = 17'b0_0_0_0_0_0_1_00_0_00_0_111_0;
  localparam ov_t L_RWB  = 17'b0_0_0_1_0_1_0_00_0_00_0_000_0;
  localparam ov_t L_J    = 17'b0_0_0_0_0_0_0_00_0_10_1_000_0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] op[2], funct[2];
  logic zero[2], mr[2];
  ov_t dut[2], exp_o[2], model_o[2], care[2];
  bit chk[2], pin[2];
  step_t cur[2];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  // instance 0: all features enabled, memready honoured; instance 1: features off
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, immzext, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    mips_multicycle_controller #(.EN_BNE(g == 0), .EN_LOGIC_IMM(g == 0), .EN_MEMREADY(g == 0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_op(op[g]), .i_funct(funct[g]), .i_zero(zero[g]),
      .i_memready(mr[g]), .o_iord(iord), .o_memwrite(memwrite), .o_irwrite(irwrite),
      .o_regdst(regdst), .o_memtoreg(memtoreg), .o_regwrite(regwrite), .o_alusrca(alusrca),
      .o_alusrcb(alusrcb), .o_immzext(immzext), .o_pcsrc(pcsrc), .o_pcen(pcen),
      .o_alucontrol(alucontrol), .o_illegal(illegal)
    );
    assign dut[g] = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
                     immzext, pcsrc, pcen, alucontrol, illegal};
  end

  function automatic bit legal(int k, logic [5:0] o);
    case (o)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
      OP_BNE, OP_ANDI, OP_ORI: return k == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] fcode(logic [5:0] fn);
    case (fn)
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2a: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic ov_t expect_out(int k, step_t s, logic [5:0] o, logic [5:0] fn, logic z, logic m);
    ov_t e = '0;
    e.alucontrol = 3'b010;
    case (s)
      FE: begin e.alusrcb = 2'b01; e.irwrite = m; e.pcen = m; end
      DE: begin e.alusrcb = 2'b11; e.illegal = !legal(k, o); end
      ADR, IEX: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      LEX: begin
        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.immzext = 1'b1;
        e.alucontrol = o == OP_ANDI ? 3'b000 : 3'b001;
      end
      RD: e.iord = 1'b1;
      WR: begin e.iord = 1'b1; e.memwrite = 1'b1; end
      MWB: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      REX: begin e.alusrca = 1'b1; e.alucontrol = fcode(fn); end
      RWB: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      BQ, BN: begin
        e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
        e.pcen = s == BQ ? z : !z;
      end
      IWB: e.regwrite = 1'b1;
      JMP: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic drive(int k, step_t s, logic [5:0] o, logic [5:0] fn, logic z, logic m);
    op[k] = o; funct[k] = fn; zero[k] = z; mr[k] = m; cur[k] = s;
    model_o[k] = expect_out(k, s, o, fn, z, k == 0 ? m : 1'b1);
    care[k] = s inside {RD, MWB, WR, RWB, IWB, JMP} ? CARE_NOAC : CARE;
    chk[k] = 1'b1;
  endtask

  task automatic lit(int k, step_t s, logic [5:0] o, logic [5:0] fn, logic z, logic m, ov_t e);
    drive(k, s, o, fn, z, m);
    exp_o[k] = e; pin[k] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic fd(int k, logic [5:0] o, logic [5:0] fn, ov_t dexp);
    lit(k, FE, o, fn, 1'b0, 1'b1, L_F1);
    lit(k, DE, o, fn, 1'b0, 1'b1, dexp);
  endtask

  task automatic run_instr(int k, logic [5:0] o, logic [5:0] fn, int pct);
    step_t q[$];
    logic m, z;
    q = '{FE, DE};
    if (legal(k, o))
      case (o)
        OP_LW: begin q.push_back(ADR); q.push_back(RD); q.push_back(MWB); end
        OP_SW: begin q.push_back(ADR); q.push_back(WR); end
        OP_R: begin q.push_back(REX); q.push_back(RWB); end
        OP_BEQ: q.push_back(BQ);
        OP_BNE: q.push_back(BN);
        OP_ADDI: begin q.push_back(IEX); q.push_back(IWB); end
        OP_ANDI, OP_ORI: begin q.push_back(LEX); q.push_back(IWB); end
        default: q.push_back(JMP);
      endcase
    foreach (q[i]) begin
      do begin
        m = $urandom_range(99) < pct;
        z = 1'($urandom_range(1));
        drive(k, q[i], o, fn, z, m);
        exp_o[k] = model_o[k]; pin[k] = 1'b0;
        @(posedge clk); #1;
      end while (k == 0 && !m && q[i] inside {FE, RD, WR});
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops[9] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J};
    int i = int'($urandom_range(9));
    return i == 9 ? 6'($urandom) : ops[i];
  endfunction

  function automatic logic [5:0] pick_fn();
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    int i = int'($urandom_range(5));
    return i == 5 ? 6'($urandom) : fns[i];
  endfunction

  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (chk[k]) begin
        checks++;
        if (((dut[k] ^ exp_o[k]) & care[k]) != '0) begin
          errors++;
          $display("FAIL dut%0d step %s: outputs=%b required=%b care=%b", k, cur[k].name(), dut[k], exp_o[k], care[k]);
        end
        if (pin[k]) begin
          checks++;
          if (((model_o[k] ^ exp_o[k]) & care[k]) != '0) begin
            errors++;
            $display("FAIL model%0d step %s: model=%b required=%b", k, cur[k].name(), model_o[k], exp_o[k]);
          end
        end
      end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    chk = '{1'b0, 1'b0};
    pin = '{1'b0, 1'b0};
    for (int k = 0; k < 2; k++) begin
      op[k] = '0; funct[k] = '0; zero[k] = 1'b0; mr[k] = 1'b0;
      care[k] = CARE; exp_o[k] = '0; model_o[k] = '0;
    end
    @(posedge clk); #1;
    fork
      begin lit(0, FE, OP_SW, 6'h00, 1'b0, 1'b1, L_F1); lit(0, FE, OP_LW, 6'h00, 1'b1, 1'b1, L_F1); end
      begin lit(1, FE, OP_LW, 6'h00, 1'b0, 1'b0, L_F1); lit(1, FE, OP_J, 6'h00, 1'b1, 1'b0, L_F1); end
    join
    rst_n = 1'b1;
    fork
      begin
        fd(0, OP_LW, 6'h00, L_D);
        lit(0, ADR, OP_LW, 6'h00, 1'b0, 1'b1, L_ADR);
        lit(0, RD, OP_LW, 6'h00, 1'b0, 1'b1, L_RD);
        lit(0, MWB, OP_LW, 6'h00, 1'b0, 1'b1, L_MWB);
        repeat (3) lit(0, FE, OP_J, 6'h00, 1'b0, 1'b0, L_F0);
        fd(0, OP_J, 6'h00, L_D);
        lit(0, JMP, OP_J, 6'h00, 1'b0, 1'b1, L_J);
        fd(0, OP_BEQ, 6'h00, L_D); lit(0, BQ, OP_BEQ, 6'h00, 1'b1, 1'b1, L_BR1);
        fd(0, OP_BEQ, 6'h00, L_D); lit(0, BQ, OP_BEQ, 6'h00, 1'b0, 1'b1, L_BR0);
        fd(0, OP_BNE, 6'h00, L_D); lit(0, BN, OP_BNE, 6'h00, 1'b0, 1'b1, L_BR1);
        fd(0, OP_BNE, 6'h00, L_D); lit(0, BN, OP_BNE, 6'h00, 1'b1, 1'b1, L_BR0);
        fd(0, OP_ORI, 6'h00, L_D);
        lit(0, LEX, OP_ORI, 6'h00, 1'b0, 1'b1, L_ORI);
        lit(0, IWB, OP_ORI, 6'h00, 1'b0, 1'b1, L_IWB);
        fd(0, OP_R, 6'h2a, L_D);
        lit(0, REX, OP_R, 6'h2a, 1'b0, 1'b1, L_SLT);
        lit(0, RWB, OP_R, 6'h2a, 1'b0, 1'b1, L_RWB);
        fd(0, OP_SW, 6'h00, L_D);
        lit(0, ADR, OP_SW, 6'h00, 1'b0, 1'b1, L_ADR);
        repeat (2) lit(0, WR, OP_SW, 6'h00, 1'b0, 1'b0, L_WR);
        // reset while the store is still waiting: write strobe must vanish at once
        rst_n = 1'b0;
        lit(0, FE, OP_SW, 6'h00, 1'b0, 1'b1, L_F1);
        rst_n = 1'b1;
      end
      begin
        fd(1, OP_BNE, 6'h00, L_DILL);
        fd(1, OP_ANDI, 6'h00, L_DILL);
        fd(1, OP_ORI, 6'h00, L_DILL);
        lit(1, FE, OP_LW, 6'h00, 1'b0, 1'b0, L_F1);
        lit(1, DE, OP_LW, 6'h00, 1'b0, 1'b0, L_D);
        lit(1, ADR, OP_LW, 6'h00, 1'b0, 1'b0, L_ADR);
        lit(1, RD, OP_LW, 6'h00, 1'b0, 1'b0, L_RD);
        lit(1, MWB, OP_LW, 6'h00, 1'b0, 1'b0, L_MWB);
        chk[1] = 1'b0;
      end
    join
    fork
      begin repeat (150) run_instr(0, pick_op(), pick_fn(), 65); chk[0] = 1'b0; end
      begin repeat (150) run_instr(1, pick_op(), pick_fn(), 50); chk[1] = 1'b0; end
    join
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
